mem_stage: RTL

- MEM stage of the five-stage MIPS pipeline, directly downstream of execute.
- Registers execute's outputs and performs data loads and stores over a request/ack SRAM-style bus.
- Generates byte strobes, sign/zero-extends loads, detects misaligned accesses, and stalls the pipeline while a transfer is in flight.
- Feeds the writeback stage.

---
 rtl/mem_stage_pkg.sv | 34 +++
 rtl/mem_stage_align.sv | 69 ++++++
 rtl/mem_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM stage: load/store op codes, FSM encodings,
// exception bit positions and the alignment rule used by both the FSM and datapath.
package mem_stage_pkg;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [1:0] MEM_IDLE = 2'd0;
  localparam logic [1:0] MEM_REQ  = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;
  localparam logic [1:0] MEM_DONE = 2'd3;

  localparam int EXC_ADEL = 0;
  localparam int EXC_ADES = 1;

  // Halfword ops need an even address, word ops a 4-byte aligned one.
  function automatic logic misaligned(input logic [7:0] op, input logic [1:0] addr_lo);
    logic m;
    m = 1'b0;
    case (op)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: m = addr_lo[0];
      EXE_LW_OP, EXE_SW_OP:             m = (addr_lo != 2'b00);
      default:                          m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational byte-lane logic: store strobes/replicated data, address
// error flags and little-endian load extraction with sign/zero extension.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [7:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [1:0]  exc,
  output logic [31:0] load_value
);

  logic       mis;
  logic [7:0] lane_byte;
  logic [15:0] lane_half;

  assign mis = misaligned(op, addr_lo);

  always_comb begin
    exc = 2'b00;
    exc[EXC_ADEL] = mem_read && mis;
    exc[EXC_ADES] = mem_write && mis;
  end

  always_comb begin
    wstrb = 4'b0000;
    wdata = store_data;
    case (op)
      EXE_SB_OP: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      EXE_SH_OP: begin
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      EXE_SW_OP: wstrb = 4'b1111;
      default:   wstrb = 4'b0000;
    endcase
    // Loads and non-memory ops never drive byte enables.
    if (!mem_write) wstrb = 4'b0000;
  end

  always_comb begin
    case (addr_lo)
      2'd0:    lane_byte = load_word[7:0];
      2'd1:    lane_byte = load_word[15:8];
      2'd2:    lane_byte = load_word[23:16];
      default: lane_byte = load_word[31:24];
    endcase
    lane_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
  end

  always_comb begin
    case (op)
      EXE_LB_OP:  load_value = {{24{lane_byte[7]}}, lane_byte};
      EXE_LBU_OP: load_value = {24'd0, lane_byte};
      EXE_LH_OP:  load_value = {{16{lane_half[15]}}, lane_half};
      EXE_LHU_OP: load_value = {16'd0, lane_half};
      default:    load_value = load_word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: input register, request/ack bus FSM and load data
// register; stalls upstream while a transfer is outstanding.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  input  logic [7:0]        aluop_in,
  input  logic [31:0]       alu_result_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_to_reg_in,
  input  logic              reg_write_in,
  input  logic [4:0]        write_reg_in,
  input  logic [31:0]       inst_in,
  output logic              data_req,
  output logic              data_wr,
  output logic [3:0]        data_wstrb,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [31:0]       wb_result,
  output logic [4:0]        wb_waddr,
  output logic              wb_we,
  output logic [31:0]       inst_out,
  output logic              mem_stall,
  output logic              adel,
  output logic              ades,
  output logic [ADDR_W-1:0] bad_vaddr
);

  logic [1:0]        state, state_next;
  logic              advance, start;
  logic [7:0]        aluop_q;
  logic [31:0]       alu_result_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] store_data_q;
  logic              mem_read_q, mem_write_q, mem_to_reg_q, reg_write_q;
  logic [4:0]        write_reg_q;
  logic [31:0]       inst_q;
  logic [DATA_W-1:0] load_data_q;
  logic [1:0]        exc;
  logic [31:0]       load_value;

  assign mem_stall = (state == MEM_REQ) || (state == MEM_WAIT);
  assign advance   = !stall_in && !mem_stall;
  assign start     = (mem_read_in || mem_write_in) && !misaligned(aluop_in, mem_addr_in[1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      aluop_q      <= '0;
      alu_result_q <= '0;
      addr_q       <= '0;
      store_data_q <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      inst_q       <= '0;
    end else if (advance) begin
      aluop_q      <= aluop_in;
      alu_result_q <= alu_result_in;
      addr_q       <= mem_addr_in;
      store_data_q <= store_data_in;
      mem_read_q   <= mem_read_in;
      mem_write_q  <= mem_write_in;
      mem_to_reg_q <= mem_to_reg_in;
      reg_write_q  <= reg_write_in;
      write_reg_q  <= write_reg_in;
      inst_q       <= inst_in;
    end
  end

  // Bus responses outside REQ/WAIT (e.g. left over from before a reset) are dropped.
  always_comb begin
    state_next = state;
    case (state)
      MEM_REQ: begin
        if (data_addr_ok && data_data_ok) state_next = MEM_DONE;
        else if (data_addr_ok)            state_next = MEM_WAIT;
      end
      MEM_WAIT: if (data_data_ok) state_next = MEM_DONE;
      default:  if (advance) state_next = start ? MEM_REQ : MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= MEM_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst)                            load_data_q <= '0;
    else if (mem_stall && data_data_ok) load_data_q <= data_rdata;
  end

  mem_align u_align (
    .op         (aluop_q),
    .addr_lo    (addr_q[1:0]),
    .mem_read   (mem_read_q),
    .mem_write  (mem_write_q),
    .store_data (store_data_q),
    .load_word  (load_data_q),
    .wstrb      (data_wstrb),
    .wdata      (data_wdata),
    .exc        (exc),
    .load_value (load_value)
  );

  assign adel      = exc[EXC_ADEL];
  assign ades      = exc[EXC_ADES];
  assign bad_vaddr = (adel || ades) ? addr_q : '0;

  assign data_req  = (state == MEM_REQ);
  assign data_wr   = mem_write_q;
  assign data_addr = addr_q;

  assign wb_result = mem_to_reg_q ? load_value : alu_result_q;
  assign wb_waddr  = write_reg_q;
  assign wb_we     = reg_write_q && !adel && !ades && !mem_stall;
  assign inst_out  = inst_q;

endmodule
